// File: rtl/mult_share_sched.sv
// Round-robin scheduler that shares one sequential multiplier between two requesters.
// Each response is issued a fixed LATENCY cycles after the start pulse, so multiplier timing never leaks out.
module mult_share_sched #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  input  logic [WIDTH-1:0]     req_a_0,
  input  logic [WIDTH-1:0]     req_a_1,
  input  logic [WIDTH-1:0]     req_b_0,
  input  logic [WIDTH-1:0]     req_b_1,
  output logic                 resp_valid_0,
  output logic                 resp_valid_1,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic                 mult_start,
  output logic [WIDTH-1:0]     mult_multiplier,
  output logic [WIDTH-1:0]     mult_multiplicand,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_done,
  output logic                 err
);

  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               id_q, id_d;
  logic               prio_q, prio_d;
  logic               got_done_q, got_done_d;
  logic               err_q, err_d;
  logic               grant_0, grant_1;

  // prio_q names the requester that wins a tie; it always points away from the last grant.
  always_comb begin
    grant_0 = req_valid_0 && (!req_valid_1 || !prio_q);
    grant_1 = req_valid_1 && (!req_valid_0 || prio_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    id_d       = id_q;
    prio_d     = prio_q;
    got_done_d = got_done_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (grant_0 || grant_1) begin
          a_d     = grant_1 ? req_a_1 : req_a_0;
          b_d     = grant_1 ? req_b_1 : req_b_0;
          id_d    = grant_1;
          prio_d  = !grant_1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d      = '0;
        got_done_d = 1'b0;
        prod_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mult_done && !got_done_q) begin
          prod_d     = mult_product;
          got_done_d = 1'b1;
        end
        // WAIT spans LATENCY-1 cycles so RESP lands LATENCY cycles after the start pulse.
        if (cnt_q == CW'(LATENCY - 2)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (!got_done_q) begin
          err_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready_0       = rst && (state_q == IDLE) && grant_0;
    req_ready_1       = rst && (state_q == IDLE) && grant_1;
    mult_start        = (state_q == ISSUE);
    mult_multiplier   = (state_q == IDLE) ? '0 : a_q;
    mult_multiplicand = (state_q == IDLE) ? '0 : b_q;
    resp_valid_0      = (state_q == RESP) && !id_q;
    resp_valid_1      = (state_q == RESP) && id_q;
    resp_product      = ((state_q == RESP) && got_done_q) ? prod_q : '0;
    err               = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      id_q       <= 1'b0;
      prio_q     <= 1'b0;
      got_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      prod_q     <= prod_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
      got_done_q <= got_done_d;
      err_q      <= err_d;
    end
  end

endmodule
